uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of uart_rx.
- Captures each completed frame (good data, framing error, and optionally line break) into a first-word-fall-through FIFO.
- Presents entries to the host logic over a valid/ready handshake.
- Tracks overflow with a sticky flag and a saturating drop counter, so lost bytes are visible to software.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_rx_fifo.sv | 111 +++++++++++
 tb/tb_uart_rx_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: entry layout stored in the receive FIFO.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      error;
    logic                      isBreak;
  } rx_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic first-word-fall-through FIFO; head visible one edge after push, occupancy kept in a count register.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind uart_rx with sticky overflow and saturating drop counter.
// Optional break markers are enabled by defining UART_RX_FIFO_BREAK_MARKER_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [7:0]                 i_rxData,
  input  logic                       i_rxDataValid,
  input  logic                       i_rxDataError,
  input  logic                       i_rxIsBreak,
  output logic [7:0]                 o_data,
  output logic                       o_error,
  output logic                       o_break,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_overflow,
  output logic [DROP_CNT_WIDTH-1:0]  o_dropCount,
  input  logic                       i_clearOverflow
);

  rx_entry_t wr_entry;
  rx_entry_t head;
  logic      data_stb;
  logic      push;
  logic      pop;
  logic      drop;
  logic      full;
  logic      empty;

  assign data_stb = i_rxDataValid | i_rxDataError;

`ifdef UART_RX_FIFO_BREAK_MARKER_EN
  logic brk_prev;
  logic brk_pend;
  logic marker;

  // A marker that collides with a data strobe is deferred until a strobe-free cycle.
  assign marker = (i_rxIsBreak && !brk_prev) || brk_pend;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      brk_prev <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      brk_prev <= i_rxIsBreak;
      brk_pend <= marker && data_stb;
    end
  end

  assign push             = data_stb | marker;
  assign wr_entry.data    = data_stb ? i_rxData : 8'h00;
  assign wr_entry.error   = i_rxDataError;
  assign wr_entry.isBreak = !data_stb;
  assign o_break          = head.isBreak;
`else
  logic unused_break;

  assign unused_break     = i_rxIsBreak ^ head.isBreak;
  assign push             = data_stb;
  assign wr_entry.data    = i_rxData;
  assign wr_entry.error   = i_rxDataError;
  assign wr_entry.isBreak = 1'b0;
  assign o_break          = 1'b0;
`endif

  assign o_valid = !empty;
  assign pop     = !empty && i_ready;
  assign drop    = push && full && !pop;
  assign o_data  = head.data;
  assign o_error = head.error;
  assign o_full  = full;

  sync_fifo #(
    .WIDTH ($bits(rx_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .reset     (i_reset),
    .push      (push),
    .push_data (wr_entry),
    .pop       (pop),
    .head      (head),
    .count     (o_count),
    .full      (full),
    .empty     (empty)
  );

  // A drop in the clearing cycle restarts the count at one rather than losing it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_overflow  <= 1'b0;
      o_dropCount <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (i_clearOverflow)
        o_dropCount <= DROP_CNT_WIDTH'(1);
      else if (o_dropCount != '1)
        o_dropCount <= o_dropCount + DROP_CNT_WIDTH'(1);
    end else if (i_clearOverflow) begin
      o_overflow  <= 1'b0;
      o_dropCount <= '0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, DROP_CNT_WIDTH=8).
module tb_uart_rx_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_err;
  logic       rx_brk;
  logic [7:0] data;
  logic       error;
  logic       brk;
  logic       valid;
  logic       ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       clr;

  int vectors;
  int miscompares;

  uart_rx_fifo #(.DEPTH(16), .DROP_CNT_WIDTH(8)) dut (
    .i_clk           (clk),
    .i_reset         (rst),
    .i_rxData        (rx_data),
    .i_rxDataValid   (rx_vld),
    .i_rxDataError   (rx_err),
    .i_rxIsBreak     (rx_brk),
    .o_data          (data),
    .o_error         (error),
    .o_break         (brk),
    .o_valid         (valid),
    .i_ready         (ready),
    .o_count         (count),
    .o_full          (full),
    .o_overflow      (overflow),
    .o_dropCount     (drop_cnt),
    .i_clearOverflow (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic e);
    rx_data = d;
    rx_vld  = !e;
    rx_err  = e;
    tick();
    rx_vld  = 1'b0;
    rx_err  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'(i + 8'h40);
      rx_vld  = i[0];
      rx_err  = !i[0];
      clr     = 1'b0;
      tick();
    end
    rx_vld = 1'b0;
    rx_err = 1'b0;
    rst    = 1'b0;
    tick();
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid); end
    vectors++;
    if (count !== 5'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0 || full !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got ovf=%b drop=%0d full=%b want 0/0/0", overflow, drop_cnt, full);
    end
  endtask

  task automatic test_basic();
    push_byte(8'hAC, 1'b0);
    vectors++;
    if (valid !== 1'b1 || data !== 8'hAC) begin
      miscompares++; $display("FAIL first_push_latency got vld=%b data=%h want 1/ac", valid, data);
    end
    push_byte(8'h55, 1'b1);
    vectors++;
    if (count !== 5'd2 || data !== 8'hAC || error !== 1'b0) begin
      miscompares++; $display("FAIL two_entries got cnt=%0d data=%h err=%b want 2/ac/0", count, data, error);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    vectors++;
    if (count !== 5'd1 || data !== 8'h55 || error !== 1'b1) begin
      miscompares++; $display("FAIL after_pop got cnt=%0d data=%h err=%b want 1/55/1", count, data, error);
    end
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    vectors++;
    if (valid !== 1'b0 || count !== 5'd0) begin
      miscompares++; $display("FAIL pop_empty got vld=%b cnt=%0d want 0/0", valid, count);
    end
    rx_data = 8'h3C;
    rx_vld  = 1'b1;
    rx_err  = 1'b1;
    tick();
    rx_vld  = 1'b0;
    rx_err  = 1'b0;
    vectors++;
    if (count !== 5'd1 || data !== 8'h3C || error !== 1'b1) begin
      miscompares++; $display("FAIL both_strobes got cnt=%0d data=%h err=%b want 1/3c/1", count, data, error);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
    vectors++;
    if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
      miscompares++; $display("FAIL fill got full=%b cnt=%0d ovf=%b want 1/16/0", full, count, overflow);
    end
    push_byte(8'hFF, 1'b0);
    vectors++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1 || count !== 5'd16) begin
      miscompares++; $display("FAIL drop got ovf=%b drop=%0d cnt=%0d want 1/1/16", overflow, drop_cnt, count);
    end
    ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (valid !== 1'b1 || data !== 8'(i)) begin
        miscompares++; $display("FAIL drain_%0d got vld=%b data=%h want 1/%h", i, valid, data, 8'(i));
      end
      tick();
    end
    ready = 1'b0;
    vectors++;
    if (valid !== 1'b0 || full !== 1'b0) begin
      miscompares++; $display("FAIL drained got vld=%b full=%b want 0/0", valid, full);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      miscompares++; $display("FAIL clear got ovf=%b drop=%0d want 0/0", overflow, drop_cnt);
    end
  endtask

  task automatic test_push_pop_full();
    for (int i = 0; i < 16; i++) push_byte(8'(8'h10 + i), 1'b0);
    ready = 1'b1;
    push_byte(8'hA5, 1'b0);
    vectors++;
    if (count !== 5'd16 || overflow !== 1'b0 || data !== 8'h11) begin
      miscompares++; $display("FAIL full_push_pop got cnt=%0d ovf=%b data=%h want 16/0/11", count, overflow, data);
    end
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp;
      exp = (i == 15) ? 8'hA5 : 8'(8'h11 + i);
      vectors++;
      if (valid !== 1'b1 || data !== exp) begin
        miscompares++; $display("FAIL ppf_drain_%0d got vld=%b data=%h want 1/%h", i, valid, data, exp);
      end
      tick();
    end
    ready = 1'b0;
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL ppf_empty got vld=%b want 0", valid); end
  endtask

  task automatic test_saturate();
    rx_data = 8'h99;
    rx_vld  = 1'b1;
    for (int i = 0; i < 16 + 300; i++) tick();
    vectors++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL saturate got drop=%0d ovf=%b want 255/1", drop_cnt, overflow);
    end
    clr = 1'b1;
    tick();
    clr    = 1'b0;
    rx_vld = 1'b0;
    vectors++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
      miscompares++; $display("FAIL clear_vs_drop got drop=%0d ovf=%b want 1/1", drop_cnt, overflow);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (count !== 5'd0 || valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
      miscompares++; $display("FAIL midop_reset got cnt=%0d vld=%b ovf=%b drop=%0d want 0/0/0/0", count, valid, overflow, drop_cnt);
    end
  endtask

  task automatic test_break();
    rx_brk = 1'b0;
    tick();
    tick();
    rx_brk = 1'b1;
    for (int i = 0; i < 50; i++) tick();
    rx_brk = 1'b0;
    tick();
`ifdef UART_RX_FIFO_BREAK_MARKER_EN
    vectors++;
    if (count !== 5'd1 || data !== 8'h00 || error !== 1'b0 || brk !== 1'b1) begin
      miscompares++; $display("FAIL break_marker got cnt=%0d data=%h err=%b brk=%b want 1/00/0/1", count, data, error, brk);
    end
    ready = 1'b1;
    tick();
    ready   = 1'b0;
    rx_brk  = 1'b1;
    rx_data = 8'h77;
    rx_vld  = 1'b1;
    tick();
    rx_vld = 1'b0;
    tick();
    vectors++;
    if (count !== 5'd2 || data !== 8'h77 || brk !== 1'b0) begin
      miscompares++; $display("FAIL break_collide_data got cnt=%0d data=%h brk=%b want 2/77/0", count, data, brk);
    end
    ready = 1'b1;
    tick();
    vectors++;
    if (data !== 8'h00 || brk !== 1'b1) begin
      miscompares++; $display("FAIL break_collide_marker got data=%h brk=%b want 00/1", data, brk);
    end
    tick();
    ready  = 1'b0;
    rx_brk = 1'b0;
`else
    vectors++;
    if (count !== 5'd0 || valid !== 1'b0) begin
      miscompares++; $display("FAIL break_ignored got cnt=%0d vld=%b want 0/0", count, valid);
    end
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    rx_data     = 8'h00;
    rx_vld      = 1'b0;
    rx_err      = 1'b0;
    rx_brk      = 1'b0;
    ready       = 1'b0;
    clr         = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_push_pop_full();
    test_saturate();
    test_break();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
